// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the programmable sequence-detector controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Serial history register, fill counter and length-masked pattern comparator.
module seq_shift_match
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               x,
  input  logic               clr_fill,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  // Only MAX_LEN-1 past bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] next_hist;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_p1;
  logic               mismatch;

  assign next_hist = {hist, x};
  assign fill_p1   = {1'b0, fill} + (LEN_W+1)'(1);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mismatch = mismatch | (next_hist[i] ^ pattern[i]);
    end
  end

  assign hit = (fill_p1 >= {1'b0, len}) && !mismatch;

  // NOTE: the history is a few flops, not a RAM, so it takes the async reset
  // like every other register; a memory array would be left unreset instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= next_hist[MAX_LEN-2:0];
      if (clr_fill)        fill <= '0;
      else if (fill < len) fill <= fill_p1[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Runtime-configured serial sequence detector: config handshake, arm/abort FSM,
// saturating match counter with optional stop target.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t             state, next_state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic               cfg_loaded;
  logic               cfg_fire;
  logic               shift_en, arm, match, hit;
  logic [CNT_W-1:0]   count_inc;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state == ST_ARMED);
  assign done      = (state == ST_DONE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign count_inc = (&match_count) ? match_count : match_count + CNT_W'(1);

  seq_shift_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
    .clk      (clk),
    .reset    (reset),
    .clr      (arm),
    .shift_en (shift_en),
    .x        (x),
    .clr_fill (hit && !overlap_q),
    .len      (len_q),
    .pattern  (pattern_q),
    .hit      (hit)
  );

  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned (no latch).
    next_state = state;
    shift_en   = 1'b0;
    arm        = 1'b0;
    match      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A config handshake in the same cycle takes priority over start.
        if (!cfg_fire && start && cfg_loaded) begin
          next_state = ST_ARMED;
          arm        = 1'b1;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (x_valid) begin
          shift_en = 1'b1;
          match    = hit;
          if (hit && (target_q != '0) && (count_inc == target_q)) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (start) begin
          next_state = ST_ARMED;
          arm        = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q  <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b0;
      target_q   <= '0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (cfg_fire) begin
      if (len_legal(int'(cfg_len), MAX_LEN)) begin
        pattern_q  <= cfg_pattern;
        len_q      <= cfg_len;
        overlap_q  <= cfg_overlap;
        target_q   <= cfg_target;
        cfg_loaded <= 1'b1;
        cfg_err    <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y           <= 1'b0;
      match_count <= '0;
    end else begin
      y <= match;
      if (arm)        match_count <= '0;
      else if (match) match_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner cases and
// random stimulus compared against a queue-based reference model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clk, reset;
  logic               cfg_valid, cfg_ready, cfg_overlap;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target, match_count;
  logic               start, abort, x, x_valid, y, busy, done, cfg_err;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .y(y), .match_count(match_count), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (mode 0=idle, 1=armed, 2=done) ----------------
  int  m_mode, m_cnt, m_len, m_tgt;
  bit  m_loaded, m_err, m_y, m_ov;
  bit  [7:0] m_pat;
  bit  m_q[$];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_loaded = 0; m_err = 0; m_y = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit hit;
    m_y = 0;
    case (m_mode)
      0: begin
        if (cfg_valid) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
            m_tgt = int'(cfg_target); m_err = 0; m_loaded = 1;
          end else m_err = 1;
        end else if (start && m_loaded) begin
          m_mode = 1; m_cnt = 0; m_q.delete();
        end
      end
      1: begin
        if (abort) m_mode = 0;
        else if (x_valid) begin
          m_q.push_back(x);
          if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
          hit = (m_q.size() >= m_len);
          for (int k = 0; k < m_len && hit; k++)
            if (m_q[m_q.size() - m_len + k] != m_pat[m_len-1-k]) hit = 0;
          if (hit) begin
            m_y = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ov) m_q.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
          end
        end
      end
      default: begin
        if (abort) m_mode = 0;
        else if (start) begin m_mode = 1; m_cnt = 0; m_q.delete(); end
      end
    endcase
  endtask

  task automatic compare_model(input string tag);
    check({tag, " y"},       y,           m_y);
    check({tag, " count"},   match_count, m_cnt);
    check({tag, " busy"},    busy,        m_mode == 1);
    check({tag, " done"},    done,        m_mode == 2);
    check({tag, " cfg_err"}, cfg_err,     m_err);
    check({tag, " ready"},   cfg_ready,   m_mode == 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit cv, input int pat, input int len, input bit ov, input int tgt,
                       input bit st, input bit ab, input bit xx, input bit xv);
    cfg_valid = cv; cfg_pattern = 8'(pat); cfg_len = 4'(len); cfg_overlap = ov;
    cfg_target = 8'(tgt); start = st; abort = ab; x = xx; x_valid = xv;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit cv; int pat; int len; bit ov; int tgt; bit st; bit ab; bit x; bit xv;
    bit ey; int ec; bit eb; bit ed; bit ee;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit cv, input int pat, input int len, input bit ov, input int tgt,
                     input bit st, input bit ab, input bit xx, input bit xv,
                     input bit ey, input int ec, input bit eb, input bit ed, input bit ee);
    vec_t v;
    v = '{cv, pat, len, ov, tgt, st, ab, xx, xv, ey, ec, eb, ed, ee};
    tbl.push_back(v);
  endtask

  // Shorthand for one serial bit while armed (no config, start or abort).
  task automatic add_bit(input bit xx, input bit xv, input bit ey, input int ec,
                         input bit eb, input bit ed, input bit ee);
    add(0, 0, 0, 0, 0, 0, 0, xx, xv, ey, ec, eb, ed, ee);
  endtask

  int d_bits[12] = '{0,0,1,1,0,1,1,0,0,1,1,0};
  int d_y[12]    = '{0,0,0,0,1,0,0,1,0,0,0,1};
  int d_c[12]    = '{0,0,0,0,1,1,1,2,2,2,2,3};
  int o_bits[5]  = '{1,0,1,0,1};
  int o_y1[5]    = '{0,0,1,0,1};
  int o_c1[5]    = '{0,0,1,1,2};
  int o_y0[5]    = '{0,0,1,0,0};
  int o_c0[5]    = '{0,0,1,1,1};

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare_model("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Config: illegal len, start ignored, legal 0110/4, start arms.
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1);
    add(1, 8'h06, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) add_bit(d_bits[i], 1, d_y[i], d_c[i], 1, 0, 0);
    add_bit(0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 3, 0, 0, 0);
    // Overlap on: 101 in 1,0,1,0,1 gives two matches.
    add(1, 8'h05, 3, 1, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add_bit(o_bits[i], 1, o_y1[i], o_c1[i], 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 2, 0, 0, 0);
    // Overlap off: only one match.
    add(1, 8'h05, 3, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add_bit(o_bits[i], 1, o_y0[i], o_c0[i], 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0);
    // len beyond MAX_LEN: error flagged, previous config still arms.
    add(1, 8'hFF, 9, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 1);
    add(0, 0,     0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    // Config and start together: config latched, start ignored.
    add(1, 8'h01, 2, 1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    // Target 2 with x_valid toggling; DONE on second match, then x ignored.
    add_bit(0, 1, 0, 0, 1, 0, 0);
    add_bit(1, 0, 0, 0, 1, 0, 0);
    add_bit(1, 1, 1, 1, 1, 0, 0);
    add_bit(0, 0, 0, 1, 1, 0, 0);
    add_bit(0, 1, 0, 1, 1, 0, 0);
    add_bit(1, 0, 0, 1, 1, 0, 0);
    add_bit(1, 1, 1, 2, 0, 1, 0);
    add_bit(0, 1, 0, 2, 0, 1, 0);
    add_bit(1, 1, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 2, 0, 0, 0);

    foreach (tbl[r]) begin
      drive(tbl[r].cv, tbl[r].pat, tbl[r].len, tbl[r].ov, tbl[r].tgt,
            tbl[r].st, tbl[r].ab, tbl[r].x, tbl[r].xv);
      step();
      check($sformatf("row%0d y", r),       y,           tbl[r].ey);
      check($sformatf("row%0d count", r),   match_count, tbl[r].ec);
      check($sformatf("row%0d busy", r),    busy,        tbl[r].eb);
      check($sformatf("row%0d done", r),    done,        tbl[r].ed);
      check($sformatf("row%0d cfg_err", r), cfg_err,     tbl[r].ee);
      check($sformatf("row%0d ready", r),   cfg_ready,   !(tbl[r].eb || tbl[r].ed));
    end

    // Collision: abort on the edge that would complete 01.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1); step();
    check("collision y", y, 0);
    check("collision count", match_count, 0);
    check("collision busy", busy, 0);
    check("collision ready", cfg_ready, 1);

    // Counter saturation with len=1, no overlap.
    drive(1, 8'h01, 1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    end
    check("sat count", match_count, 255);
    check("sat y", y, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    check("sat zero bit y", y, 0);
    check("sat hold count", match_count, 255);

    // Async reset mid-ARMED with count 3.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    end
    check("pre-reset count", match_count, 3);
    check("pre-reset busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async y", y, 0);
    check("async count", match_count, 0);
    check("async busy", busy, 0);
    check("async ready", cfg_ready, 1);
    #2 reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    check("start after reset busy", busy, 0);
    check("start after reset ready", cfg_ready, 1);

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 9) == 0, int'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      step();
      compare_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence-detector controller.
- Accepts a pattern configuration through a valid/ready handshake and arms on start.
- Samples a qualified serial bit stream and pulses y on each match. Overlapping or non-overlapping matching is selectable.
- Counts matches and stops at a programmable target.
- Sits between the control/config logic and the FSM-level serial input. It replaces hard-wired detectors with one reusable, runtime-configured engine.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
LEN_W, 4, width of length field; must hold MAX_LEN (clog2(MAX_LEN)+1).
CNT_W, 8, width of match counter and target.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
cfg_valid  input  1  config offered.
cfg_ready  output  1  controller can accept config (IDLE only).
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last.
cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN.
cfg_overlap  input  1  1 = overlapping matches allowed.
cfg_target  input  CNT_W  matches before DONE; 0 = run until abort.
start  input  1  arm detector (IDLE, config loaded).
abort  input  1  return to IDLE from ARMED/DONE.
x  input  1  serial data bit.
x_valid  input  1  x qualified this cycle.
y  output  1  one-cycle match pulse.
match_count  output  CNT_W  matches since arm.
busy  output  1  state == ARMED.
done  output  1  state == DONE.
cfg_err  output  1  sticky: last config had illegal length.

Behaviour:
- Reset (reset=0, async) state and outputs:
  - State = IDLE; cfg_ready=1; y=0; match_count=0; busy=0; done=0; cfg_err=0.
  - cfg_loaded=0; history and fill counter cleared.
- States: IDLE, ARMED, DONE. Encoding lives in the package.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, latch pattern/len/overlap/target.
  - cfg_len==0 or >MAX_LEN: config is not latched, cfg_err=1, cfg_loaded unchanged.
  - Legal config: cfg_err=0, cfg_loaded=1.
  - start=1 with cfg_loaded=1 -> ARMED. On that edge, clear match_count, history and fill.
  - start without cfg_loaded is ignored.
  - If cfg handshake and start occur in the same cycle, config is latched and start is ignored.
- ARMED:
  - cfg_ready=0; busy=1.
  - On each edge with x_valid=1:
    - next_hist = {history[MAX_LEN-2:0], x}; fill saturates at len.
    - Match when (fill+1 >= len) and next_hist[len-1:0] == pattern[len-1:0].
  - On a match, at the same edge:
    - y=1 for exactly the following cycle.
    - match_count increments; it saturates at all-ones.
    - If overlap=0, fill resets to 0, so the next match needs len fresh bits.
  - x_valid=0: no shift, y=0, no state change.
  - If target!=0 and the post-increment count == target -> DONE on the same edge.
  - abort=1 -> IDLE; match_count is held for readout. Abort wins over a simultaneous match: no y, no increment.
- DONE:
  - done=1, busy=0; x ignored; y=0.
  - abort=1 -> IDLE.
  - start=1 re-arms with the same config: -> ARMED, count cleared.
- Asynchronous reset mid-ARMED discards config (cfg_loaded=0).
- len=1: every x_valid bit equal to pattern[0] matches. Overlap has no effect.

Decomposition:
- Package seq_ctrl_pkg:
  - State localparams ST_IDLE/ST_ARMED/ST_DONE.
  - Default MAX_LEN/CNT_W constants.
  - Length-legality function.
- Sub-module seq_shift_match:
  - Contains the history shift register, fill counter and masked comparator.
  - Inputs: shift_en, x, clr_fill, len, pattern.
  - Output: hit (combinational, from next_hist).
- The top holds the FSM, config registers, counter and handshakes.

Test Plan:
- Reset: reset=0 mid-ARMED with count=3 -> all outputs reset values immediately, without waiting for a clock; cfg_ready=1; start then ignored until new config.
- Config: cfg_len=0 -> cfg_err=1, start ignored. Then pattern=4'b0110, len=4 -> cfg_err=0; start -> busy=1 next cycle.
- Detection: pattern 0110, len 4, overlap=1, target=0. Stream 0,0,1,1,0,1,1,0,0,1,1,0 -> y pulses after bits 5, 8 and 12; match_count=3.
- Overlap: pattern 101, len 3, stream 1,0,1,0,1:
  - overlap=1 -> 2 pulses, count=2.
  - overlap=0 -> 1 pulse, count=1.
- Target/qualifier: target=2, x_valid toggling 1/0 -> non-valid bits ignored; DONE on 2nd match edge with done=1; further matching bits give no y. abort -> IDLE.
- Collision: abort asserted on the edge that completes a match -> IDLE, y=0, count unchanged.
